// File: rtl/sram_bus_arbiter.sv
// Arbitrates the CPU fetch and data ports onto one SRAM bus. Byte, half and word
// accesses become a word address plus byte mask; load data is aligned and extended.
module sram_bus_arbiter #(
  parameter int unsigned ACCESS_CYCLES = 2,
  parameter int unsigned ADDR_W        = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [31:0]       inst_addr,
  output logic [31:0]       inst_rdata,
  output logic              inst_ack,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [1:0]        data_size,
  input  logic              data_signed,
  input  logic [31:0]       data_addr,
  input  logic [31:0]       data_wdata,
  output logic [31:0]       data_rdata,
  output logic              data_ack,
  output logic              data_misalign,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              read_op,
  output logic              write_op,
  output logic [31:0]       bus_data_write,
  output logic [3:0]        byte_mask,
  input  logic [31:0]       bus_data_read
);

  localparam int unsigned CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               grant_data_q, grant_data_d;
  logic               we_q, we_d;
  logic [1:0]         size_q, size_d;
  logic               signed_q, signed_d;
  logic [1:0]         off_q, off_d;

  logic [ADDR_W-1:0]  bus_addr_d;
  logic               read_op_d, write_op_d;
  logic [31:0]        bus_data_write_d;
  logic [3:0]         byte_mask_d;
  logic               inst_ack_d, data_ack_d, data_misalign_d;
  logic [31:0]        inst_rdata_d, data_rdata_d;

  logic               misalign_c;
  logic [3:0]         store_mask_c;
  logic [31:0]        store_lanes_c;
  logic [31:0]        shifted_c;
  logic [31:0]        load_data_c;
  logic               unused_addr_bits;

  // Address bits above the SRAM window and the fetch byte offset carry no meaning here.
  assign unused_addr_bits = ^{inst_addr[31:ADDR_W+2], inst_addr[1:0], data_addr[31:ADDR_W+2]};

  always_comb begin
    misalign_c = 1'b0;
    case (data_size)
      2'b01:   misalign_c = data_addr[0];
      2'b10:   misalign_c = |data_addr[1:0];
      2'b11:   misalign_c = 1'b1;
      default: misalign_c = 1'b0;
    endcase
  end

  // Store byte enables and lane replication so any enabled lane sees the right bytes.
  always_comb begin
    store_mask_c  = 4'b1111;
    store_lanes_c = data_wdata;
    case (data_size)
      2'b00: begin
        store_mask_c  = 4'b0001 << data_addr[1:0];
        store_lanes_c = {4{data_wdata[7:0]}};
      end
      2'b01: begin
        store_mask_c  = 4'b0011 << {data_addr[1], 1'b0};
        store_lanes_c = {2{data_wdata[15:0]}};
      end
      default: begin
        store_mask_c  = 4'b1111;
        store_lanes_c = data_wdata;
      end
    endcase
  end

  // Load alignment: bring the addressed byte/half to bit 0, then extend.
  assign shifted_c = bus_data_read >> {off_q, 3'b000};

  always_comb begin
    load_data_c = shifted_c;
    case (size_q)
      2'b00:   load_data_c = signed_q ? {{24{shifted_c[7]}}, shifted_c[7:0]}
                                      : {24'd0, shifted_c[7:0]};
      2'b01:   load_data_c = signed_q ? {{16{shifted_c[15]}}, shifted_c[15:0]}
                                      : {16'd0, shifted_c[15:0]};
      default: load_data_c = shifted_c;
    endcase
  end

  // Next-state and next-output logic; bus fields hold their value unless reloaded.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    grant_data_d     = grant_data_q;
    we_d             = we_q;
    size_d           = size_q;
    signed_d         = signed_q;
    off_d            = off_q;
    bus_addr_d       = bus_addr;
    read_op_d        = read_op;
    write_op_d       = write_op;
    bus_data_write_d = bus_data_write;
    byte_mask_d      = byte_mask;
    inst_ack_d       = 1'b0;
    data_ack_d       = 1'b0;
    data_misalign_d  = 1'b0;
    inst_rdata_d     = '0;
    data_rdata_d     = '0;

    case (state_q)
      IDLE: begin
        if (data_req) begin
          grant_data_d = 1'b1;
          we_d         = data_we;
          size_d       = data_size;
          signed_d     = data_signed;
          off_d        = data_addr[1:0];
          if (misalign_c) begin
            state_d         = RESP;
            data_ack_d      = 1'b1;
            data_misalign_d = 1'b1;
          end else begin
            state_d          = ACCESS;
            cnt_d            = CNT_LOAD;
            bus_addr_d       = data_addr[ADDR_W+1:2];
            read_op_d        = ~data_we;
            write_op_d       = data_we;
            byte_mask_d      = data_we ? store_mask_c : 4'b1111;
            bus_data_write_d = data_we ? store_lanes_c : 32'd0;
          end
        end else if (inst_req) begin
          grant_data_d     = 1'b0;
          we_d             = 1'b0;
          size_d           = 2'b10;
          signed_d         = 1'b0;
          off_d            = 2'b00;
          state_d          = ACCESS;
          cnt_d            = CNT_LOAD;
          bus_addr_d       = inst_addr[ADDR_W+1:2];
          read_op_d        = 1'b1;
          write_op_d       = 1'b0;
          byte_mask_d      = 4'b1111;
          bus_data_write_d = 32'd0;
        end
      end

      ACCESS: begin
        if (cnt_q == '0) begin
          state_d    = RESP;
          read_op_d  = 1'b0;
          write_op_d = 1'b0;
          if (grant_data_q) begin
            data_ack_d   = 1'b1;
            data_rdata_d = we_q ? 32'd0 : load_data_c;
          end else begin
            inst_ack_d   = 1'b1;
            inst_rdata_d = bus_data_read;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d    = IDLE;
        read_op_d  = 1'b0;
        write_op_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset clears strobes immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      grant_data_q   <= 1'b0;
      we_q           <= 1'b0;
      size_q         <= 2'b00;
      signed_q       <= 1'b0;
      off_q          <= 2'b00;
      bus_addr       <= '0;
      read_op        <= 1'b0;
      write_op       <= 1'b0;
      bus_data_write <= '0;
      byte_mask      <= '0;
      inst_ack       <= 1'b0;
      data_ack       <= 1'b0;
      data_misalign  <= 1'b0;
      inst_rdata     <= '0;
      data_rdata     <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      grant_data_q   <= grant_data_d;
      we_q           <= we_d;
      size_q         <= size_d;
      signed_q       <= signed_d;
      off_q          <= off_d;
      bus_addr       <= bus_addr_d;
      read_op        <= read_op_d;
      write_op       <= write_op_d;
      bus_data_write <= bus_data_write_d;
      byte_mask      <= byte_mask_d;
      inst_ack       <= inst_ack_d;
      data_ack       <= data_ack_d;
      data_misalign  <= data_misalign_d;
      inst_rdata     <= inst_rdata_d;
      data_rdata     <= data_rdata_d;
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter with a small byte-masked SRAM model on the bus.
module tb_sram_bus_arbiter;

  localparam int unsigned ADDR_W = 20;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              inst_req = 1'b0;
  logic [31:0]       inst_addr = '0;
  logic [31:0]       inst_rdata;
  logic              inst_ack;
  logic              data_req = 1'b0;
  logic              data_we = 1'b0;
  logic [1:0]        data_size = 2'b00;
  logic              data_signed = 1'b0;
  logic [31:0]       data_addr = '0;
  logic [31:0]       data_wdata = '0;
  logic [31:0]       data_rdata;
  logic              data_ack;
  logic              data_misalign;
  logic [ADDR_W-1:0] bus_addr;
  logic              read_op;
  logic              write_op;
  logic [31:0]       bus_data_write;
  logic [3:0]        byte_mask;
  logic [31:0]       bus_data_read;

  int errors = 0;
  int checks = 0;

  sram_bus_arbiter #(.ACCESS_CYCLES(2), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_ack(inst_ack),
    .data_req(data_req), .data_we(data_we), .data_size(data_size), .data_signed(data_signed),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_ack(data_ack), .data_misalign(data_misalign),
    .bus_addr(bus_addr), .read_op(read_op), .write_op(write_op),
    .bus_data_write(bus_data_write), .byte_mask(byte_mask), .bus_data_read(bus_data_read)
  );

  always #5 clk = ~clk;

  // SRAM model: 64 words, byte-masked writes on each write_op edge.
  logic [31:0] mem [0:63];
  assign bus_data_read = mem[bus_addr[5:0]];

  always @(posedge clk) begin
    if (write_op) begin
      for (int b = 0; b < 4; b++)
        if (byte_mask[b]) mem[bus_addr[5:0]][8*b +: 8] <= bus_data_write[8*b +: 8];
    end
  end

  // Bus monitor: strobe cycles, last bus fields seen, and mid-access changes.
  int          stb_total = 0;
  int          wr_total = 0;
  int          chg_total = 0;
  logic        prev_stb = 1'b0;
  logic [55:0] prev_bus = '0;
  logic [ADDR_W-1:0] stb_addr = '0;
  logic [3:0]  stb_mask = '0;
  logic [31:0] stb_wdata = '0;

  always @(negedge clk) begin
    if (read_op || write_op) begin
      stb_total <= stb_total + 1;
      if (write_op) wr_total <= wr_total + 1;
      if (prev_stb && (prev_bus != {bus_addr, byte_mask, bus_data_write}))
        chg_total <= chg_total + 1;
      stb_addr  <= bus_addr;
      stb_mask  <= byte_mask;
      stb_wdata <= bus_data_write;
    end
    prev_stb <= read_op || write_op;
    prev_bus <= {bus_addr, byte_mask, bus_data_write};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One data transaction; returns ack latency in cycles from driving req (0 = timed out).
  task automatic data_txn(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic mis, output int lat);
    @(posedge clk); #1;
    data_req = 1'b1; data_we = we; data_size = size; data_signed = sgn;
    data_addr = addr; data_wdata = wdata;
    lat = 0; rdata = '0; mis = 1'b0;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      @(posedge clk); #1;
      if (data_ack) begin lat = c; rdata = data_rdata; mis = data_misalign; end
    end
    data_req = 1'b0;
  endtask

  task automatic inst_txn(input logic [31:0] addr, output logic [31:0] rdata, output int lat);
    @(posedge clk); #1;
    inst_req = 1'b1; inst_addr = addr;
    lat = 0; rdata = '0;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      @(posedge clk); #1;
      if (inst_ack) begin lat = c; rdata = inst_rdata; end
    end
    inst_req = 1'b0;
  endtask

  initial begin
    logic [31:0] rd, ird;
    logic        mis;
    int          lat, dl, il, s0, w0, c0, acks, nack;
    int          ack_at [3];

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    chk("rst_read_op", 32'(read_op), 32'd0);
    chk("rst_write_op", 32'(write_op), 32'd0);
    chk("rst_acks", {29'd0, inst_ack, data_ack, data_misalign}, 32'd0);
    chk("rst_bus_addr", 32'(bus_addr), 32'd0);
    chk("rst_mask_wdata", bus_data_write | 32'(byte_mask), 32'd0);
    chk("rst_rdata", inst_rdata | data_rdata, 32'd0);
    rst = 1'b0;

    // 1: store word then load it back
    s0 = stb_total; w0 = wr_total; c0 = chg_total;
    data_txn(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, rd, mis, lat);
    chk("sw_latency", 32'(lat), 32'd3);
    chk("sw_misalign", 32'(mis), 32'd0);
    chk("sw_write_cycles", 32'(wr_total - w0), 32'd2);
    chk("sw_strobe_cycles", 32'(stb_total - s0), 32'd2);
    chk("sw_bus_addr", 32'(stb_addr), 32'h0000_0004);
    chk("sw_mask", 32'(stb_mask), 32'h0000_000F);
    chk("sw_wdata", stb_wdata, 32'hDEAD_BEEF);
    chk("sw_stable", 32'(chg_total - c0), 32'd0);
    s0 = stb_total; w0 = wr_total;
    data_txn(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, rd, mis, lat);
    chk("lw_latency", 32'(lat), 32'd3);
    chk("lw_rdata", rd, 32'hDEAD_BEEF);
    chk("lw_read_cycles", 32'(stb_total - s0), 32'd2);
    chk("lw_no_write", 32'(wr_total - w0), 32'd0);

    // 2: byte store into lane 3 -> word becomes A5ADBEEF
    data_txn(1'b1, 2'b00, 1'b0, 32'h0000_0013, 32'h1234_56A5, rd, mis, lat);
    chk("sb_mask", 32'(stb_mask), 32'h0000_0008);
    chk("sb_wdata", stb_wdata, 32'hA5A5_A5A5);
    data_txn(1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'h0, rd, mis, lat);
    chk("lb_signed", rd, 32'hFFFF_FFA5);
    data_txn(1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'h0, rd, mis, lat);
    chk("lbu", rd, 32'h0000_00A5);
    data_txn(1'b0, 2'b00, 1'b1, 32'h0000_0012, 32'h0, rd, mis, lat);
    chk("lb_signed_lane2", rd, 32'hFFFF_FFAD);

    // 3: half store into upper half -> word becomes 8001BEEF
    data_txn(1'b1, 2'b01, 1'b0, 32'h0000_0012, 32'h0000_8001, rd, mis, lat);
    chk("sh_mask", 32'(stb_mask), 32'h0000_000C);
    chk("sh_wdata", stb_wdata, 32'h8001_8001);
    data_txn(1'b0, 2'b01, 1'b1, 32'h0000_0012, 32'h0, rd, mis, lat);
    chk("lh_signed", rd, 32'hFFFF_8001);
    data_txn(1'b0, 2'b01, 1'b0, 32'h0000_0010, 32'h0, rd, mis, lat);
    chk("lhu_low", rd, 32'h0000_BEEF);
    data_txn(1'b0, 2'b10, 1'b0, 32'h8000_0010, 32'h0, rd, mis, lat);
    chk("lw_upper_addr_ignored", rd, 32'h8001_BEEF);
    chk("lw_upper_bus_addr", 32'(stb_addr), 32'h0000_0004);

    // 4: simultaneous requests, data port wins
    @(posedge clk); #1;
    data_req = 1'b1; data_we = 1'b0; data_size = 2'b10; data_signed = 1'b0; data_addr = 32'h10;
    inst_req = 1'b1; inst_addr = 32'h10;
    dl = 0; il = 0; rd = '0; ird = '0;
    for (int c = 1; c <= 20 && il == 0; c++) begin
      @(posedge clk); #1;
      if (data_ack && dl == 0) begin dl = c; rd = data_rdata; data_req = 1'b0; end
      if (inst_ack && il == 0) begin il = c; ird = inst_rdata; inst_req = 1'b0; end
    end
    data_req = 1'b0; inst_req = 1'b0;
    chk("prio_data_latency", 32'(dl), 32'd3);
    chk("prio_inst_latency", 32'(il), 32'd7);
    chk("prio_data_rdata", rd, 32'h8001_BEEF);
    chk("prio_inst_rdata", ird, 32'h8001_BEEF);

    // 5: misaligned requests answer next cycle with no strobe
    s0 = stb_total;
    data_txn(1'b0, 2'b01, 1'b1, 32'h0000_0001, 32'h0, rd, mis, lat);
    chk("mis_lh_latency", 32'(lat), 32'd1);
    chk("mis_lh_flag", 32'(mis), 32'd1);
    chk("mis_lh_rdata", rd, 32'd0);
    data_txn(1'b1, 2'b10, 1'b0, 32'h0000_0012, 32'hFFFF_FFFF, rd, mis, lat);
    chk("mis_sw_flag", 32'(mis), 32'd1);
    data_txn(1'b0, 2'b11, 1'b0, 32'h0000_0010, 32'h0, rd, mis, lat);
    chk("mis_size11_flag", 32'(mis), 32'd1);
    chk("mis_no_strobes", 32'(stb_total - s0), 32'd0);
    data_txn(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, rd, mis, lat);
    chk("mis_mem_untouched", rd, 32'h8001_BEEF);

    // 6: reset mid-access drops the strobe and discards the transaction
    @(posedge clk); #1;
    inst_req = 1'b1; inst_addr = 32'h10;
    @(posedge clk); #1;
    chk("rst_mid_read_on", 32'(read_op), 32'd1);
    #2 rst = 1'b1; inst_req = 1'b0;
    #1;
    chk("rst_mid_read_drop", 32'(read_op), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    acks = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (inst_ack || data_ack) acks++;
    end
    chk("rst_mid_no_ack", 32'(acks), 32'd0);
    inst_txn(32'h0000_0010, ird, lat);
    chk("post_rst_fetch_latency", 32'(lat), 32'd3);
    chk("post_rst_fetch_rdata", ird, 32'h8001_BEEF);

    // Held fetch request re-arbitrates every four cycles
    @(posedge clk); #1;
    inst_req = 1'b1; inst_addr = 32'h10;
    nack = 0;
    for (int i = 0; i < 3; i++) ack_at[i] = 0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (inst_ack) begin
        if (nack < 3) ack_at[nack] = c;
        nack++;
      end
    end
    inst_req = 1'b0;
    chk("held_ack_count", 32'(nack), 32'd3);
    chk("held_ack0", 32'(ack_at[0]), 32'd3);
    chk("held_ack1", 32'(ack_at[1]), 32'd7);
    chk("held_ack2", 32'(ack_at[2]), 32'd11);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
